// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the 4x4 systolic array core.
package tpu_pkg;

    localparam int DATA_BITS  = 32;   // four signed int8 lanes
    localparam int DATAC_BITS = 128;  // four signed 32-bit accumulators
    localparam int SA_DIM     = 4;
    localparam int STEP_LAST  = 9;    // last MAC step: k + r + c max = 3 + 3 + 3
    localparam int STEP_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/tpu_pe.sv
// Processing element: one signed 8x8 MAC with a wrapping 32-bit accumulator
// and registered pass-through of the A (rightward) and B (downward) operands.
module tpu_pe (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic signed [7:0] a_in,
    input  logic signed [7:0] b_in,
    output logic signed [7:0] a_out,
    output logic signed [7:0] b_out,
    output logic [31:0]       acc
);

    logic signed [15:0] prod;

    assign prod = a_in * b_in;

    // Accumulate the sign-extended product and forward operands one hop per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clr) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            acc   <= acc + {{16{prod[15]}}, prod};
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/sa_core.sv
// 4x4 output-stationary systolic array: captures A/B, skews them into the
// grid over ten steps, and presents C = A x B with a done flag.
module sa_core #(
    parameter int DATA_BITS  = tpu_pkg::DATA_BITS,
    parameter int DATAC_BITS = tpu_pkg::DATAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sa_rst_n,
    input  logic [DATA_BITS-1:0]  local_buffer_A0,
    input  logic [DATA_BITS-1:0]  local_buffer_A1,
    input  logic [DATA_BITS-1:0]  local_buffer_A2,
    input  logic [DATA_BITS-1:0]  local_buffer_A3,
    input  logic [DATA_BITS-1:0]  local_buffer_B0,
    input  logic [DATA_BITS-1:0]  local_buffer_B1,
    input  logic [DATA_BITS-1:0]  local_buffer_B2,
    input  logic [DATA_BITS-1:0]  local_buffer_B3,
    output logic                  done,
    output logic [DATAC_BITS-1:0] local_buffer_C0,
    output logic [DATAC_BITS-1:0] local_buffer_C1,
    output logic [DATAC_BITS-1:0] local_buffer_C2,
    output logic [DATAC_BITS-1:0] local_buffer_C3
);

    import tpu_pkg::*;

    state_t                state, state_nx;
    logic [STEP_W-1:0]     step;
    logic [DATA_BITS-1:0]  a_word [SA_DIM];
    logic [DATA_BITS-1:0]  b_word [SA_DIM];
    // a_cap[k][r] = A[r][k]; b_cap[k][c] = B[k][c]
    logic signed [7:0]     a_cap  [SA_DIM][SA_DIM];
    logic signed [7:0]     b_cap  [SA_DIM][SA_DIM];
    logic signed [7:0]     a_inj  [SA_DIM];
    logic signed [7:0]     b_inj  [SA_DIM];
    logic signed [7:0]     a_h    [SA_DIM][SA_DIM+1];
    logic signed [7:0]     b_v    [SA_DIM+1][SA_DIM];
    logic [31:0]           acc    [SA_DIM][SA_DIM];
    logic [DATAC_BITS-1:0] c_row  [SA_DIM];
    logic                  mac_en;
    logic                  clr;

    assign a_word[0] = local_buffer_A0;
    assign a_word[1] = local_buffer_A1;
    assign a_word[2] = local_buffer_A2;
    assign a_word[3] = local_buffer_A3;
    assign b_word[0] = local_buffer_B0;
    assign b_word[1] = local_buffer_B1;
    assign b_word[2] = local_buffer_B2;
    assign b_word[3] = local_buffer_B3;

    assign clr    = !sa_rst_n;
    assign mac_en = (state == S_RUN) && sa_rst_n;
    assign done   = (state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state: a low run request always returns to IDLE
    always_comb begin
        state_nx = state;
        if (!sa_rst_n) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nx = S_RUN;
                S_RUN:   if (step == STEP_W'(STEP_LAST)) state_nx = S_DONE;
                S_DONE:  state_nx = S_DONE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Step counter: zero on capture, advances once per RUN edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
        end else if (!sa_rst_n || state != S_RUN) begin
            step <= '0;
        end else if (step != STEP_W'(STEP_LAST)) begin
            step <= step + 1'b1;
        end
    end

    // Operand capture on the IDLE->RUN edge; inputs are ignored afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < SA_DIM; k++)
                for (int unsigned e = 0; e < SA_DIM; e++) begin
                    a_cap[k][e] <= '0;
                    b_cap[k][e] <= '0;
                end
        end else if (!sa_rst_n) begin
            for (int unsigned k = 0; k < SA_DIM; k++)
                for (int unsigned e = 0; e < SA_DIM; e++) begin
                    a_cap[k][e] <= '0;
                    b_cap[k][e] <= '0;
                end
        end else if (state == S_IDLE) begin
            for (int unsigned k = 0; k < SA_DIM; k++)
                for (int unsigned e = 0; e < SA_DIM; e++) begin
                    a_cap[k][e] <= a_word[k][DATA_BITS-1-8*e -: 8];
                    b_cap[k][e] <= b_word[k][DATA_BITS-1-8*e -: 8];
                end
        end
    end

    // Skew injection: row r gets A[r][k] at step k+r, column c gets B[k][c] at step k+c
    always_comb begin
        for (int unsigned i = 0; i < SA_DIM; i++) begin
            a_inj[i] = '0;
            b_inj[i] = '0;
        end
        if (state == S_RUN) begin
            for (int unsigned i = 0; i < SA_DIM; i++)
                for (int unsigned k = 0; k < SA_DIM; k++)
                    if (step == STEP_W'(k + i)) begin
                        a_inj[i] = a_cap[k][i];
                        b_inj[i] = b_cap[k][i];
                    end
        end
    end

    for (genvar r = 0; r < SA_DIM; r++) begin : g_row
        assign a_h[r][0] = a_inj[r];
        assign b_v[0][r] = b_inj[r];
        for (genvar c = 0; c < SA_DIM; c++) begin : g_col
            tpu_pe u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .en    (mac_en),
                .a_in  (a_h[r][c]),
                .b_in  (b_v[r][c]),
                .a_out (a_h[r][c+1]),
                .b_out (b_v[r+1][c]),
                .acc   (acc[r][c])
            );
        end
    end

    // Pack accumulators into result rows, lane 0 in the MSBs
    always_comb begin
        for (int unsigned r = 0; r < SA_DIM; r++) begin
            c_row[r] = '0;
            for (int unsigned c = 0; c < SA_DIM; c++)
                c_row[r][DATAC_BITS-1-32*c -: 32] = acc[r][c];
        end
    end

    assign local_buffer_C0 = c_row[0];
    assign local_buffer_C1 = c_row[1];
    assign local_buffer_C2 = c_row[2];
    assign local_buffer_C3 = c_row[3];

endmodule

// File: tb/tb_sa_core.sv
// Self-checking bench for sa_core: table of operand sets with expected C,
// plus directed abort and asynchronous-reset sequences.
module tb_sa_core;

    typedef struct {
        string    name;
        byte      a [4][4];   // a[r][k]
        byte      b [4][4];   // b[k][c]
        int       c [4][4];   // expected c[r][c]
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sa_rst_n;
    logic [31:0]  A0, A1, A2, A3, B0, B1, B2, B3;
    logic         done;
    logic [127:0] C0, C1, C2, C3;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vt [5];

    sa_core #(.DATA_BITS(32), .DATAC_BITS(128)) dut (
        .clk             (clk),
        .rst             (rst),
        .sa_rst_n        (sa_rst_n),
        .local_buffer_A0 (A0),
        .local_buffer_A1 (A1),
        .local_buffer_A2 (A2),
        .local_buffer_A3 (A3),
        .local_buffer_B0 (B0),
        .local_buffer_B1 (B1),
        .local_buffer_B2 (B2),
        .local_buffer_B3 (B3),
        .done            (done),
        .local_buffer_C0 (C0),
        .local_buffer_C1 (C1),
        .local_buffer_C2 (C2),
        .local_buffer_C3 (C3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] word_a(input vec_t v, input int k);
        logic [31:0] w;
        for (int r = 0; r < 4; r++) w[31-8*r -: 8] = v.a[r][k];
        return w;
    endfunction

    function automatic logic [31:0] word_b(input vec_t v, input int k);
        logic [31:0] w;
        for (int c = 0; c < 4; c++) w[31-8*c -: 8] = v.b[k][c];
        return w;
    endfunction

    function automatic logic [127:0] row_c(input vec_t v, input int r);
        logic [127:0] w;
        for (int c = 0; c < 4; c++) w[127-32*c -: 32] = v.c[r][c];
        return w;
    endfunction

    // Plain matrix multiply used for the mixed-value vectors
    function automatic vec_t matmul(input vec_t v);
        vec_t o = v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                o.c[r][c] = 0;
                for (int k = 0; k < 4; k++)
                    o.c[r][c] += int'(v.a[r][k]) * int'(v.b[k][c]);
            end
        return o;
    endfunction

    task automatic set_inputs(input vec_t v);
        A0 = word_a(v, 0); A1 = word_a(v, 1); A2 = word_a(v, 2); A3 = word_a(v, 3);
        B0 = word_b(v, 0); B1 = word_b(v, 1); B2 = word_b(v, 2); B3 = word_b(v, 3);
    endtask

    // Raise the run request and count edges (capture edge = 1) until done
    task automatic start_and_wait(input vec_t v, output int edge_n);
        set_inputs(v);
        sa_rst_n = 1'b1;
        edge_n = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin
                A0 = $urandom; A1 = $urandom; A2 = $urandom; A3 = $urandom;
                B0 = $urandom; B1 = $urandom; B2 = $urandom; B3 = $urandom;
            end
            if (done) begin
                edge_n = e;
                break;
            end
        end
    endtask

    task automatic check_rows(input vec_t v, input string tag);
        check({tag, ".C0"}, C0, row_c(v, 0));
        check({tag, ".C1"}, C1, row_c(v, 1));
        check({tag, ".C2"}, C2, row_c(v, 2));
        check({tag, ".C3"}, C3, row_c(v, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // Identity A, B = 1..16 row-major, C = B
        vt[0].name = "identity";
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vt[0].a[i][j] = (i == j) ? 8'sd1 : 8'sd0;
                vt[0].b[i][j] = byte'(i*4 + j + 1);
                vt[0].c[i][j] = i*4 + j + 1;
            end
        vt[1].name = "pos_max";
        vt[2].name = "neg_max";
        vt[3].name = "neg_x_pos";
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vt[1].a[i][j] = 127;  vt[1].b[i][j] = 127;  vt[1].c[i][j] = 64516;
                vt[2].a[i][j] = -128; vt[2].b[i][j] = -128; vt[2].c[i][j] = 65536;
                vt[3].a[i][j] = -128; vt[3].b[i][j] = 127;  vt[3].c[i][j] = 32'hFFFF0200;
            end
        vt[4].name = "mixed";
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vt[4].a[i][j] = byte'((i - j) * 40 + i);
                vt[4].b[i][j] = byte'(i * 17 - j * 29 + 3);
            end
        vt[4] = matmul(vt[4]);

        rst = 1'b1;
        sa_rst_n = 1'b0;
        A0 = '0; A1 = '0; A2 = '0; A3 = '0;
        B0 = '0; B1 = '0; B2 = '0; B3 = '0;
        #12;
        check("reset.done", {127'b0, done}, 128'd0);
        check("reset.C", C0 | C1 | C2 | C3, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back operations, run request low for exactly one cycle between each
        for (int i = 0; i < 5; i++) begin
            sa_rst_n = 1'b0;
            @(negedge clk);
            check({vt[i].name, ".clr_done"}, {127'b0, done}, 128'd0);
            check({vt[i].name, ".clr_C"}, C0 | C1 | C2 | C3, 128'd0);
            start_and_wait(vt[i], lat);
            check({vt[i].name, ".latency"}, 128'(lat), 128'd11);
            check_rows(vt[i], vt[i].name);
            repeat (3) @(negedge clk);
            check({vt[i].name, ".hold_done"}, {127'b0, done}, 128'd1);
            check({vt[i].name, ".hold_C3"}, C3, row_c(vt[i], 3));
            @(negedge clk);
        end

        // Abort at step 5, then restart
        sa_rst_n = 1'b0;
        @(negedge clk);
        set_inputs(vt[4]);
        sa_rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort.pre_done", {127'b0, done}, 128'd0);
        @(negedge clk);
        sa_rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort.done", {127'b0, done}, 128'd0);
        check("abort.C", C0 | C1 | C2 | C3, 128'd0);
        @(negedge clk);
        start_and_wait(vt[2], lat);
        check("abort.latency", 128'(lat), 128'd11);
        check_rows(vt[2], "abort");

        // Asynchronous reset pulsed between edges mid-RUN
        @(negedge clk);
        sa_rst_n = 1'b0;
        @(negedge clk);
        set_inputs(vt[0]);
        sa_rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("async.pre_C0_nonzero", {127'b0, C0 != '0}, 128'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async.done", {127'b0, done}, 128'd0);
        check("async.C", C0 | C1 | C2 | C3, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        start_and_wait(vt[0], lat);
        check("async.latency", 128'(lat), 128'd11);
        check_rows(vt[0], "async");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
